// File: rtl/aes_dec_iter_core.sv
// Iterative AES-128/256 inverse cipher. Round keys are expanded once into a local store
// and can be reused by the next block so that it skips re-expansion.
module aes_dec_iter_core #(
  parameter int KEY_W     = 128,
  parameter int KEY_CACHE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     cipher_text,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_reuse,
  output logic [127:0]     plain_text,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [3:0]       round_idx
);
  localparam int         NR       = (KEY_W == 256) ? 14 : 10;
  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] KX_FIRST = (KEY_W == 256) ? 4'd2 : 4'd1;

  if (KEY_W != 128 && KEY_W != 256) begin : g_bad_key_w
    $error("aes_dec_iter_core: KEY_W must be 128 or 256");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] imc_coef(input int unsigned n);
    case (n)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // Byte k of the block is bits [127-8k -: 8]; state[r][c] is byte r+4c.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        a[r + 4*c] = isbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]) ^ k[127 - 8*(r + 4*c) -: 8];
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++) begin
        m[r + 4*c] = last ? a[r + 4*c] : '0;
        if (!last)
          for (int unsigned j = 0; j < 4; j++)
            m[r + 4*c] = m[r + 4*c] ^ gmul(a[j + 4*c], imc_coef((j + 4 - r) % 4));
      end
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[127 - 8*i -: 8] = m[i];
    return o;
  endfunction

  // rk[idx] from rk[idx-1] (and rk[idx-2] for AES-256, whose odd keys skip RotWord/Rcon).
  function automatic logic [127:0] next_rk(input logic [127:0] p1, input logic [127:0] p2,
                                           input logic [3:0] idx);
    logic [127:0] base;
    logic [31:0]  t, w0, w1, w2, w3;
    logic [7:0]   rc;
    logic [3:0]   n;
    base = (KEY_W == 256) ? p2 : p1;
    n    = (KEY_W == 256) ? {1'b0, idx[3:1]} : idx;
    t    = p1[31:0];
    if (KEY_W == 128 || !idx[0]) begin
      rc = 8'h01;
      for (int unsigned i = 1; i < 14; i++) if (4'(i) < n) rc = xt(rc);
      t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
    end else begin
      t = sub_word(t);
    end
    w0 = base[127:96] ^ t;
    w1 = base[95:64]  ^ w0;
    w2 = base[63:32]  ^ w1;
    w3 = base[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_DEC, S_DONE} state_t;

  state_t       r_st, w_st_nxt;
  logic [127:0] r_rk [0:NR];
  logic [127:0] r_state, r_pt;
  logic [3:0]   r_idx;
  logic         r_cached;
  logic         w_accept, w_hit;
  logic [127:0] w_rk_rd, w_rk_p1, w_rk_p2, w_rk_new, w_round;

  assign w_accept = in_valid && (r_st == S_IDLE);
  assign w_hit    = (KEY_CACHE != 0) && key_reuse && r_cached;
  assign w_rk_rd  = r_rk[r_idx];
  assign w_rk_p1  = r_rk[r_idx - 4'd1];
  assign w_rk_p2  = r_rk[r_idx - 4'd2];
  assign w_rk_new = next_rk(w_rk_p1, w_rk_p2, r_idx);
  assign w_round  = inv_round(r_state, w_rk_rd, r_idx == 4'd0);

  assign in_ready   = (r_st == S_IDLE);
  assign busy       = (r_st != S_IDLE);
  assign out_valid  = (r_st == S_DONE);
  assign plain_text = r_pt;
  assign round_idx  = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE:   if (w_accept) w_st_nxt = w_hit ? S_DEC : S_KEYEXP;
      S_KEYEXP: if (r_idx == NR_IDX) w_st_nxt = S_DEC;
      S_DEC:    if (r_idx == 4'd0) w_st_nxt = S_DONE;
      S_DONE:   if (out_ready) w_st_nxt = S_IDLE;
      default:  w_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_cached <= 1'b0;
      r_pt     <= '0;
      r_state  <= '0;
    end else begin
      case (r_st)
        S_IDLE: if (w_accept) begin
          r_state <= cipher_text;
          if (w_hit) begin
            r_idx <= NR_IDX;
          end else begin
            r_idx    <= KX_FIRST;
            r_cached <= 1'b0;
          end
        end
        S_KEYEXP: begin
          if (r_idx == NR_IDX) r_cached <= 1'b1;
          else                 r_idx    <= r_idx + 4'd1;
        end
        // Index NR only occurs on the first DEC cycle: plain AddRoundKey, no inverse round.
        S_DEC: begin
          r_state <= (r_idx == NR_IDX) ? (r_state ^ w_rk_rd) : w_round;
          if (r_idx == 4'd0) r_pt  <= w_round;
          else               r_idx <= r_idx - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_hit) begin
      r_rk[0] <= key_in[KEY_W-1 -: 128];
      if (KEY_W == 256) r_rk[1] <= key_in[127:0];
    end else if (r_st == S_KEYEXP) begin
      r_rk[r_idx] <= w_rk_new;
    end
  end

endmodule
